// File: rtl/sseg_pkg.sv
// Purpose: shared constants, the hex-to-segment table and the slot state type for the seven-segment scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sseg_pkg;

    // Register map
    localparam logic [1:0] REG_VAL_LO = 2'd0;   // value[7:0]
    localparam logic [1:0] REG_VAL_HI = 2'd1;   // value[15:8]
    localparam logic [1:0] REG_CTRL   = 2'd2;   // {blank[3:0], dp[3:0]}
    localparam logic [1:0] REG_BRIGHT = 2'd3;   // {4'b0, bright[3:0]}; reads show the digit index in [5:4]

    localparam int SUB_PHASES = 16;
    localparam int DIGITS     = 4;

    // Active-low g..a patterns for 0-9, A, b, C, d, E, F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        DEAD,
        ON,
        OFF
    } slot_state_e;

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Purpose: CPU register bus into the scan controller (write/read strobes, address, data).
// Latency: rdata is valid the cycle after rd_en.
// Backpressure: none; every strobe is accepted in the cycle it is asserted.
// Ports: wr_en, rd_en, addr[1:0], wdata[7:0] from the CPU side; rdata[7:0] back from the controller.
interface sseg_scan_ctrl_if;
    logic       wr_en;
    logic       rd_en;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport master (output wr_en, rd_en, addr, wdata, input rdata);
    modport slave  (input wr_en, rd_en, addr, wdata, output rdata);
endinterface

// File: rtl/sseg_hex_decode.sv
// Purpose: nibble to active-low seven-segment pattern (g..a).
// Latency: combinational.
// Backpressure: none.
// Ports: nib_i[3:0] hex digit in, seg_o[6:0] active-low segments out.
module sseg_hex_decode
    import sseg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    assign seg_o = HEX_SEG[nib_i];
endmodule

// File: rtl/sseg_scan_ctrl.sv
// Purpose: CPU-writable register file plus 4-digit common-anode scan with dead time and 16-step PWM brightness.
// Latency: sseg/an registered, one cycle behind the sub-phase counters; rdata one cycle after rd_en.
// Backpressure: none; writes and reads are accepted every cycle.
// Ports: OSCCLK clock, reset sync active-high, bus (sseg_scan_ctrl_if.slave register access),
//        sseg[7:0] active-low segments ([7] = dp), an[3:0] active-low digit enables (an[0] rightmost).
// Option: define SSEG_LEADING_ZERO_BLANK_EN to suppress leading zero digits 3..1.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int SUB_TICKS = 3125
) (
    input  logic            OSCCLK,
    input  logic            reset,
    sseg_scan_ctrl_if.slave bus,
    output logic [7:0]      sseg,
    output logic [3:0]      an
);
    localparam int            PW        = (SUB_TICKS > 1) ? $clog2(SUB_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SUB_TICKS - 1);
    localparam logic [3:0]    SUB_LAST  = 4'(SUB_PHASES - 1);

    // Register file
    logic [15:0] value_q;
    logic [3:0]  dp_q, blank_q, bright_q;
    logic [7:0]  rdata_q, rdata_d;

    // Scan counters
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    sub_q, sub_d;
    logic [1:0]    dig_q, dig_d;
    logic          presc_wrap, slot_start;

    // Per-slot snapshot, so CPU writes never disturb the digit currently lit
    logic [3:0] snap_nib_q, snap_bright_q;
    logic       snap_dp_q, snap_blank_q;
    logic [3:0] nib_next;

    logic [6:0]  seg_pat;
    slot_state_e slot_st;
    logic [7:0]  sseg_d, sseg_q;
    logic [3:0]  an_d, an_q;

    always_comb begin
        rdata_d = rdata_q;
        case (bus.addr)
            REG_VAL_LO: rdata_d = value_q[7:0];
            REG_VAL_HI: rdata_d = value_q[15:8];
            REG_CTRL:   rdata_d = {blank_q, dp_q};
            default:    rdata_d = {2'b00, dig_q, bright_q};
        endcase
    end

    // Reads sample the pre-write value, so a same-address read+write returns the old contents.
    always_ff @(posedge OSCCLK) begin
        if (reset) begin
            value_q  <= 16'h0000;
            dp_q     <= 4'h0;
            blank_q  <= 4'h0;
            bright_q <= 4'hF;
            rdata_q  <= 8'h00;
        end else begin
            if (bus.wr_en) begin
                case (bus.addr)
                    REG_VAL_LO: value_q[7:0]  <= bus.wdata;
                    REG_VAL_HI: value_q[15:8] <= bus.wdata;
                    REG_CTRL:   {blank_q, dp_q} <= bus.wdata;
                    default:    bright_q <= bus.wdata[3:0];
                endcase
            end
            if (bus.rd_en) begin
                rdata_q <= rdata_d;
            end
        end
    end

    always_comb begin
        presc_wrap = (presc_q == PRESC_MAX);
        slot_start = presc_wrap && (sub_q == SUB_LAST);
        presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
        sub_d      = presc_wrap ? sub_q + 4'd1 : sub_q;
        dig_d      = slot_start ? dig_q + 2'd1 : dig_q;
        nib_next   = value_q[{dig_d, 2'b00} +: 4];
    end

    always_ff @(posedge OSCCLK) begin
        if (reset) begin
            presc_q       <= '0;
            sub_q         <= 4'd0;
            dig_q         <= 2'd0;
            snap_nib_q    <= 4'h0;
            snap_dp_q     <= 1'b0;
            snap_blank_q  <= 1'b0;
            snap_bright_q <= 4'hF;
        end else begin
            presc_q <= presc_d;
            sub_q   <= sub_d;
            dig_q   <= dig_d;
            if (slot_start) begin
                snap_nib_q    <= nib_next;
                snap_dp_q     <= dp_q[dig_d];
                snap_blank_q  <= blank_q[dig_d];
                snap_bright_q <= bright_q;
            end
        end
    end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
    logic snap_sup_q;
    logic sup_next;

    assign sup_next = (dig_d != 2'd0) && ((value_q >> {dig_d, 2'b00}) == 16'h0000);

    always_ff @(posedge OSCCLK) begin
        if (reset) begin
            snap_sup_q <= 1'b0;
        end else if (slot_start) begin
            snap_sup_q <= sup_next;
        end
    end
`endif

    sseg_hex_decode u_dec (
        .nib_i (snap_nib_q),
        .seg_o (seg_pat)
    );

    // Sub-phase 0 is the dead band; sub-phases 1..bright are lit.
    always_comb begin
        slot_st = OFF;
        sseg_d  = 8'hFF;
        an_d    = 4'hF;
        if (sub_q == 4'd0) begin
            slot_st = DEAD;
        end else if (!snap_blank_q && (sub_q <= snap_bright_q)) begin
            slot_st = ON;
        end
        if (slot_st == ON) begin
`ifdef SSEG_LEADING_ZERO_BLANK_EN
            if (snap_sup_q) begin
                // Suppressed digit: segments dark, but a set dp still lights.
                if (snap_dp_q) begin
                    an_d   = ~(4'b0001 << dig_q);
                    sseg_d = 8'h7F;
                end
            end else begin
                an_d   = ~(4'b0001 << dig_q);
                sseg_d = {~snap_dp_q, seg_pat};
            end
`else
            an_d   = ~(4'b0001 << dig_q);
            sseg_d = {~snap_dp_q, seg_pat};
`endif
        end
    end

    // an and sseg share one register stage so they always switch on the same edge.
    always_ff @(posedge OSCCLK) begin
        if (reset) begin
            sseg_q <= 8'hFF;
            an_q   <= 4'hF;
        end else begin
            sseg_q <= sseg_d;
            an_q   <= an_d;
        end
    end

    assign sseg      = sseg_q;
    assign an        = an_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Purpose: self-checking bench for sseg_scan_ctrl with SUB_TICKS = 4 against a cycle-position reference model.
// Latency: checks outputs 1 time unit after every rising edge.
// Backpressure: n/a.
module tb_sseg_scan_ctrl;
    localparam int ST   = 4;
    localparam int SLOT = 16 * ST;
    localparam int SCAN = 4 * SLOT;

    logic       OSCCLK = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] sseg;
    logic [3:0] an;

    sseg_scan_ctrl_if bus ();

    sseg_scan_ctrl #(.SUB_TICKS(ST)) dut (
        .OSCCLK (OSCCLK),
        .reset  (reset),
        .bus    (bus.slave),
        .sseg   (sseg),
        .an     (an)
    );

    always #5 OSCCLK = ~OSCCLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Segment table written out from the display's digit shapes.
    logic [6:0] hex_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference model: register contents, scan position (cycles since reset) and the slot snapshot.
    logic [15:0] m_val;
    logic [3:0]  m_dp, m_blank, m_bright;
    int          st;
    logic [3:0]  s_nib, s_bright;
    logic        s_dp, s_blank, s_sup;
    logic [7:0]  e_sseg, e_rdata;
    logic [3:0]  e_an;

    // Observation statistics
    int         lit_cnt [4];
    logic [7:0] seg_seen [4];
    int         gap_run, min_gap, first_lit, cyc;
    logic [7:0] first_sseg;
    logic [3:0] first_an;
    logic       had_lit;

    task automatic take_snap(input int d);
        s_nib    = m_val[d*4 +: 4];
        s_dp     = m_dp[d];
        s_blank  = m_blank[d];
        s_bright = m_bright;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        s_sup = (d != 0) && ((m_val >> (4 * d)) == 16'h0);
`else
        s_sup = 1'b0;
`endif
    endtask

    task automatic expect_display(input int pos);
        int sub, d;
        sub    = (pos / ST) % 16;
        d      = (pos / SLOT) % 4;
        e_an   = 4'hF;
        e_sseg = 8'hFF;
        if (sub != 0 && sub <= int'(s_bright) && !s_blank) begin
            if (!s_sup) begin
                e_an   = ~(4'b0001 << d);
                e_sseg = {~s_dp, hex_tab[s_nib]};
            end else if (s_dp) begin
                e_an   = ~(4'b0001 << d);
                e_sseg = 8'h7F;
            end
        end
    endtask

    function automatic logic [7:0] model_read(input logic [1:0] a, input int pos);
        logic [1:0] d;
        d = 2'((pos / SLOT) % 4);
        case (a)
            2'd0:    return m_val[7:0];
            2'd1:    return m_val[15:8];
            2'd2:    return {m_blank, m_dp};
            default: return {2'b00, d, m_bright};
        endcase
    endfunction

    task automatic clear_stats();
        for (int i = 0; i < 4; i++) begin
            lit_cnt[i]  = 0;
            seg_seen[i] = 8'hFF;
        end
        gap_run = 0;
        min_gap = 1000;
        had_lit = 1'b0;
    endtask

    task automatic cycle(input logic rst, input logic wr, input logic rd,
                         input logic [1:0] a, input logic [7:0] wd);
        int d;
        reset     = rst;
        bus.wr_en = wr;
        bus.rd_en = rd;
        bus.addr  = a;
        bus.wdata = wd;
        @(posedge OSCCLK);
        #1;
        if (rst) begin
            m_val = 16'h0; m_dp = 4'h0; m_blank = 4'h0; m_bright = 4'hF;
            st = 0; cyc = 0;
            take_snap(0);
            e_sseg = 8'hFF; e_an = 4'hF; e_rdata = 8'h00;
        end else begin
            expect_display(st);
            if (rd) e_rdata = model_read(a, st);
            st++;
            cyc++;
            if (st % SLOT == 0) take_snap((st / SLOT) % 4);
            if (wr) begin
                case (a)
                    2'd0:    m_val[7:0]  = wd;
                    2'd1:    m_val[15:8] = wd;
                    2'd2:    {m_blank, m_dp} = wd;
                    default: m_bright = wd[3:0];
                endcase
            end
        end
        check("sseg", sseg, e_sseg);
        check("an", an, e_an);
        check("rdata", bus.rdata, e_rdata);
        if (!rst) begin
            if (an == 4'hF) begin
                gap_run++;
            end else begin
                if (had_lit && gap_run > 0 && gap_run < min_gap) min_gap = gap_run;
                gap_run = 0;
                had_lit = 1'b1;
                d = (an == 4'hE) ? 0 : (an == 4'hD) ? 1 : (an == 4'hB) ? 2 : 3;
                lit_cnt[d]++;
                seg_seen[d] = sseg;
                if (first_lit < 0) begin
                    first_lit  = cyc;
                    first_sseg = sseg;
                    first_an   = an;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] wd);
        cycle(1'b0, 1'b1, 1'b0, a, wd);
    endtask

    task automatic align_scan();
        while (st % SCAN != 0) idle(1);
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = 2'd0; bus.wdata = 8'h00;
        first_lit = -1;
        clear_stats();

        // Reset and free-run with reset contents.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 2'd0, 8'hAA);
        clear_stats();
        idle(300);
        check("first_lit_cycle", first_lit, 5);
        check("first_lit_an", first_an, 4'hE);
        check("first_lit_sseg", first_sseg, 8'hC0);

        // Value 1A2F at full brightness.
        wr(2'd0, 8'h2F); wr(2'd1, 8'h1A); wr(2'd3, 8'h0F);
        align_scan();
        clear_stats();
        idle(SCAN);
        check("d0_seg", seg_seen[0], 8'h8E);
        check("d1_seg", seg_seen[1], 8'hA4);
        check("d2_seg", seg_seen[2], 8'h88);
        check("d3_seg", seg_seen[3], 8'hF9);
        for (int i = 0; i < 4; i++) check("lit_bright15", lit_cnt[i], 60);
        check("min_gap_ge4", min_gap >= ST, 1);

        // Brightness 3, then 0.
        wr(2'd3, 8'h03);
        align_scan();
        clear_stats();
        idle(SCAN);
        for (int i = 0; i < 4; i++) check("lit_bright3", lit_cnt[i], 12);
        wr(2'd3, 8'h00);
        align_scan();
        clear_stats();
        idle(SCAN);
        for (int i = 0; i < 4; i++) check("lit_bright0", lit_cnt[i], 0);

        // Mid-slot write to the digit currently lit.
        wr(2'd3, 8'h0F);
        align_scan();
        idle(20);
        wr(2'd0, 8'h25);
        idle(10);
        check("midslot_hold_an", an, 4'hE);
        check("midslot_hold_seg", sseg, 8'h8E);
        align_scan();
        idle(10);
        check("midslot_new_an", an, 4'hE);
        check("midslot_new_seg", sseg, 8'h92);

        // Blank digit 2, dp on digits 0 and 2.
        wr(2'd2, 8'h45);
        align_scan();
        clear_stats();
        idle(SCAN);
        check("blank_d2_lit", lit_cnt[2], 0);
        check("dp_d0_seg", seg_seen[0], 8'h12);
        check("nodp_d1_seg", seg_seen[1], 8'hA4);

        // Leading zeros.
        wr(2'd2, 8'h00); wr(2'd0, 8'h50); wr(2'd1, 8'h00);
        align_scan();
        clear_stats();
        idle(SCAN);
        check("lz_d1_seg", seg_seen[1], 8'h92);
        check("lz_d0_seg", seg_seen[0], 8'hC0);
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        check("lz_d3_lit", lit_cnt[3], 0);
        check("lz_d2_lit", lit_cnt[2], 0);
`else
        check("lz_d3_seg", seg_seen[3], 8'hC0);
        check("lz_d2_seg", seg_seen[2], 8'hC0);
`endif

        // Random register traffic with occasional mid-scan reset.
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 599) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0,
                  2'($urandom_range(0, 3)),
                  8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
